lsq_fwd: RTL and testbench

- Parametrised in-order load/store queue between the core's MEM stage and the data cache (memory_system interface).
- Allocates one slot per ld/st and issues cache requests tagged with the slot ID.
- Accepts out-of-order cache completions and retires strictly in program order to the core.
- Adds store-to-load forwarding, a real full/backpressure path and an occupancy count.

---
 rtl/lsq_pkg.sv | 15 +
 rtl/lsq_fwd_match.sv | 29 ++
 rtl/lsq_fwd.sv | 139 +++++++++++++
 tb/tb_lsq_fwd.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// lsq_pkg: shared constants and helpers for the load/store queue
package lsq_pkg;
    localparam int F_OCC = 0;
    localparam int F_ST = 1;
    localparam int F_DONE = 2;
    localparam int F_N = 3;
    localparam logic RW_READ = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/lsq_fwd_match.sv
// lsq_fwd_match: youngest occupied store whose address equals the lookup address
module lsq_fwd_match #(
    parameter int DEPTH = 16,
    parameter int ADDR_W = 32,
    parameter int ID_W = 4
) (
    input  logic [DEPTH-1:0]  occ,
    input  logic [DEPTH-1:0]  st,
    input  logic [ADDR_W-1:0] addr [DEPTH],
    input  logic [ID_W-1:0]   head,
    input  logic [ADDR_W-1:0] lookup,
    output logic              hit,
    output logic [ID_W-1:0]   slot
);
    logic [ID_W-1:0] j;
    // walk oldest to youngest so the last match wins
    always_comb begin
        hit = 1'b0;
        slot = '0;
        j = head;
        for (int k = 0; k < DEPTH; k++) begin
            j = head + ID_W'(k);
            if (occ[j] && st[j] && addr[j] == lookup) begin
                hit = 1'b1;
                slot = j;
            end
        end
    end
endmodule

// File: rtl/lsq_fwd.sv
// lsq_fwd: in-order load/store queue with out-of-order cache completion
// and store-to-load forwarding
module lsq_fwd import lsq_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNTRL_W = 4,
    parameter int Z_W = 4,
    localparam int ID_W = log2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memR,
    input  logic               memW,
    input  logic [ADDR_W-1:0]  addr_in_C,
    input  logic [DATA_W-1:0]  data_in_C,
    input  logic [CNTRL_W-1:0] cntrl_in_C,
    input  logic [Z_W-1:0]     Z_in_C,
    output logic [ADDR_W-1:0]  addr_out_C,
    output logic [DATA_W-1:0]  data_out_C,
    output logic [CNTRL_W-1:0] cntrl_out_C,
    output logic [Z_W-1:0]     Z_out_C,
    output logic               ready_out_C,
    output logic [ADDR_W-1:0]  addr_out_M,
    output logic [DATA_W-1:0]  data_out_M,
    output logic               rw_out_M,
    output logic [ID_W-1:0]    ldstID_out_M,
    output logic               valid_out_M,
    input  logic [DATA_W-1:0]  data_in_M,
    input  logic [ID_W-1:0]    ldstID_in_M,
    input  logic               ready_in_M,
    input  logic               stall_in_M,
    output logic               stall_out_C,
    output logic               empty,
    output logic               full,
    output logic [ID_W:0]      count
);
    logic [F_N-1:0]     flg [DEPTH];
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [CNTRL_W-1:0] cntrl_q [DEPTH];
    logic [Z_W-1:0]     z_q [DEPTH];
    logic [DEPTH-1:0]   occ_v, st_v;
    logic [ID_W-1:0]    head, tail, hit_slot;
    logic [ID_W:0]      count_n;
    logic               enq, ret, rsp, hit;

    always_comb begin
        occ_v = '0;
        st_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_v[i] = flg[i][F_OCC];
            st_v[i] = flg[i][F_ST];
        end
    end

    assign stall_out_C = full | stall_in_M;
    assign enq = (memR | memW) & ~stall_out_C;
    assign ret = flg[head][F_OCC] & flg[head][F_DONE];
    assign rsp = ready_in_M & flg[ldstID_in_M][F_OCC] & ~flg[ldstID_in_M][F_DONE];
    assign count_n = count + (ID_W+1)'(enq) - (ID_W+1)'(ret);

    lsq_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) u_match (
        .occ(occ_v),
        .st(st_v),
        .addr(addr_q),
        .head(head),
        .lookup(addr_in_C),
        .hit(hit),
        .slot(hit_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            empty <= 1'b1;
            full <= 1'b0;
            for (int i = 0; i < DEPTH; i++) flg[i] <= '0;
        end else begin
            if (rsp) flg[ldstID_in_M][F_DONE] <= 1'b1;
            if (ret) begin
                flg[head][F_OCC] <= 1'b0;
                head <= head + 1'b1;
            end
            if (enq) begin
                flg[tail][F_OCC] <= 1'b1;
                flg[tail][F_ST] <= memW;
                flg[tail][F_DONE] <= ~memW & hit;
                tail <= tail + 1'b1;
            end
            count <= count_n;
            empty <= count_n == '0;
            full <= count_n == (ID_W+1)'(DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_out_C <= '0;
            data_out_C <= '0;
            cntrl_out_C <= '0;
            Z_out_C <= '0;
            ready_out_C <= 1'b0;
            addr_out_M <= '0;
            data_out_M <= '0;
            rw_out_M <= RW_READ;
            ldstID_out_M <= '0;
            valid_out_M <= 1'b0;
        end else begin
            ready_out_C <= ret;
            valid_out_M <= enq & (memW | ~hit);
            if (enq) begin
                addr_out_M <= addr_in_C;
                data_out_M <= data_in_C;
                rw_out_M <= memW ? RW_WRITE : RW_READ;
                ldstID_out_M <= tail;
            end
            if (ret) begin
                addr_out_C <= addr_q[head];
                data_out_C <= data_q[head];
                cntrl_out_C <= cntrl_q[head];
                Z_out_C <= z_q[head];
            end
        end
    end

    // payload needs no reset: occ gates every use
    always_ff @(posedge clk) begin
        if (rsp && !flg[ldstID_in_M][F_ST]) data_q[ldstID_in_M] <= data_in_M;
        if (enq) begin
            addr_q[tail] <= addr_in_C;
            data_q[tail] <= memW ? data_in_C : data_q[hit_slot];
            cntrl_q[tail] <= cntrl_in_C;
            z_q[tail] <= Z_in_C;
        end
    end
endmodule

// File: tb/tb_lsq_fwd.sv
// tb_lsq_fwd: scoreboard bench for lsq_fwd
module tb_lsq_fwd;
    logic clk = 0, rst = 1;
    logic memR = 0, memW = 0;
    logic [31:0] addr_in_C = 0, data_in_C = 0, data_in_M = 0;
    logic [3:0] cntrl_in_C = 0, Z_in_C = 0, ldstID_in_M = 0;
    logic ready_in_M = 0, stall_in_M = 0;
    logic [31:0] addr_out_C, data_out_C, addr_out_M, data_out_M;
    logic [3:0] cntrl_out_C, Z_out_C, ldstID_out_M;
    logic ready_out_C, rw_out_M, valid_out_M, stall_out_C, empty, full;
    logic [4:0] count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0] c;
        logic [3:0] z;
    } exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0, rets = 0;
    logic [3:0] nxt = 0;

    lsq_fwd dut (
        .clk(clk), .rst(rst), .memR(memR), .memW(memW),
        .addr_in_C(addr_in_C), .data_in_C(data_in_C), .cntrl_in_C(cntrl_in_C), .Z_in_C(Z_in_C),
        .addr_out_C(addr_out_C), .data_out_C(data_out_C), .cntrl_out_C(cntrl_out_C),
        .Z_out_C(Z_out_C), .ready_out_C(ready_out_C),
        .addr_out_M(addr_out_M), .data_out_M(data_out_M), .rw_out_M(rw_out_M),
        .ldstID_out_M(ldstID_out_M), .valid_out_M(valid_out_M),
        .data_in_M(data_in_M), .ldstID_in_M(ldstID_in_M), .ready_in_M(ready_in_M),
        .stall_in_M(stall_in_M), .stall_out_C(stall_out_C),
        .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1;
        tick();
        rst = 0;
        sb.delete();
        nxt = 0;
    endtask

    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] c, input logic [3:0] z);
        memR = ~w;
        memW = w;
        addr_in_C = a;
        data_in_C = d;
        cntrl_in_C = c;
        Z_in_C = z;
        tick();
        memR = 0;
        memW = 0;
        nxt++;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] c, input logic [3:0] z);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = c;
        e.z = z;
        sb.push_back(e);
    endtask

    task automatic resp(input logic [3:0] id, input logic [31:0] d);
        ldstID_in_M = id;
        data_in_M = d;
        ready_in_M = 1;
        tick();
        ready_in_M = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (ready_out_C) begin
            rets++;
            if (sb.size() == 0) check("spurious_ret", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("ret_addr", addr_out_C, e.a);
                check("ret_data", data_out_C, e.d);
                check("ret_cntrl", cntrl_out_C, e.c);
                check("ret_z", Z_out_C, e.z);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ida, idb, ids;
        int r0;
        reset_dut();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ready", ready_out_C, 0);
        check("rst_valid", valid_out_M, 0);

        push(32'h20, 32'hDEAD, 4'h3, 4'h5);
        op(0, 32'h20, 32'h0, 4'h3, 4'h5);
        check("ld_valid", valid_out_M, 1);
        check("ld_rw", rw_out_M, 0);
        check("ld_id", ldstID_out_M, 0);
        check("ld_addr_m", addr_out_M, 32'h20);
        tick();
        check("valid_pulse", valid_out_M, 0);
        resp(0, 32'hDEAD);
        drain("t1_drain");
        check("t1_empty", empty, 1);
        check("t1_count", count, 0);

        ida = nxt;
        push(32'h100, 32'hA, 4'h1, 4'h1);
        op(0, 32'h100, 0, 4'h1, 4'h1);
        idb = nxt;
        push(32'h104, 32'hB, 4'h2, 4'h2);
        op(0, 32'h104, 0, 4'h2, 4'h2);
        r0 = rets;
        resp(idb, 32'hB);
        repeat (3) tick();
        check("ooo_hold", rets - r0, 0);
        resp(ida, 32'hA);
        tick();
        tick();
        #6;
        check("inorder_pair", rets - r0, 2);
        drain("t2_drain");

        ids = nxt;
        push(32'h40, 32'h55, 4'h4, 4'h4);
        op(1, 32'h40, 32'h55, 4'h4, 4'h4);
        check("st_valid", valid_out_M, 1);
        check("st_rw", rw_out_M, 1);
        check("st_data_m", data_out_M, 32'h55);
        check("st_id", ldstID_out_M, ids);
        push(32'h40, 32'h55, 4'h6, 4'h7);
        op(0, 32'h40, 0, 4'h6, 4'h7);
        check("fwd_no_req", valid_out_M, 0);
        check("fwd_count", count, 2);
        resp(ids, 32'h0);
        drain("t3_drain");

        ida = nxt;
        push(32'h40, 32'h11, 4'h8, 4'h8);
        op(1, 32'h40, 32'h11, 4'h8, 4'h8);
        idb = nxt;
        push(32'h40, 32'h22, 4'h9, 4'h9);
        op(1, 32'h40, 32'h22, 4'h9, 4'h9);
        push(32'h40, 32'h22, 4'hA, 4'hA);
        op(0, 32'h40, 0, 4'hA, 4'hA);
        check("fwd2_no_req", valid_out_M, 0);
        resp(idb, 32'h0);
        resp(ida, 32'h0);
        drain("t4_drain");

        reset_dut();
        for (int k = 0; k < 16; k++) begin
            push(32'h200 + 4 * k, 32'h1000 + k, 4'(k), ~4'(k));
            op(0, 32'h200 + 4 * k, 0, 4'(k), ~4'(k));
        end
        check("full_flag", full, 1);
        check("full_count", count, 16);
        check("full_stall", stall_out_C, 1);
        memR = 1;
        addr_in_C = 32'h2FC;
        tick();
        memR = 0;
        check("full_no_req", valid_out_M, 0);
        check("full_no_enq", count, 16);
        r0 = rets;
        resp(0, 32'h1000);
        for (int i = 0; i < 10 && rets == r0; i++) tick();
        check("full_ret", rets - r0, 1);
        check("unfull_flag", full, 0);
        check("unfull_count", count, 15);
        push(32'h300, 32'h2000, 4'hC, 4'hD);
        op(0, 32'h300, 0, 4'hC, 4'hD);
        check("wrap_id", ldstID_out_M, 0);
        check("wrap_valid", valid_out_M, 1);
        check("wrap_count", count, 16);
        for (int k = 1; k < 16; k++) resp(4'(k), 32'h1000 + k);
        resp(0, 32'h2000);
        drain("t5_drain");
        check("t5_empty", empty, 1);

        reset_dut();
        for (int k = 0; k < 5; k++) op(0, 32'h400 + 4 * k, 0, 0, 0);
        check("t6_count5", count, 5);
        reset_dut();
        r0 = rets;
        resp(2, 32'hBAD);
        repeat (3) tick();
        check("late_rsp_ret", rets - r0, 0);
        check("late_ready", ready_out_C, 0);
        check("late_empty", empty, 1);
        check("late_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
